fetch_queue: RTL and testbench

Instruction-fetch front end feeding the Decoder. It issues 64-byte line reads on the Sysbus and absorbs the 8×64-bit response beats into a 128-byte circular byte buffer. It presents a 15-byte decode window with its RIP, advances that window by the byte count the Decoder reports each cycle, and flushes and refetches on a redirect.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_window_mux.sv | 22 ++
 rtl/fetch_queue.sv | 164 ++++++++++++++++
 tb/tb_fetch_queue.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// Bus tag encodings and the fetch FSM state set live here.
package fetch_pkg;

  localparam int LINE_BYTES     = 64;
  localparam int BEATS_PER_LINE = 8;

  // reqtag = {TAG_READ, TAG_MEMORY, 8'b0}
  localparam logic       TAG_READ   = 1'b1;
  localparam logic [3:0] TAG_MEMORY = 4'b0001;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACTIVE,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_window_mux.sv
// Combinational rotator: picks WINDOW_BYTES consecutive bytes out of the
// circular byte buffer starting at rd_ptr, wrapping at the buffer end.
module fetch_window_mux
  import fetch_pkg::*;
#(
  parameter int BUF_BYTES    = 128,
  parameter int WINDOW_BYTES = 15,
  parameter int PTR_W        = 7
) (
  input  logic [7:0]                buf_mem [BUF_BYTES],
  input  logic [PTR_W-1:0]          rd_ptr,
  output logic [8*WINDOW_BYTES-1:0] window
);

  for (genvar gi = 0; gi < WINDOW_BYTES; gi++) begin : g_lane
    logic [PTR_W-1:0] idx;
    // Pointer arithmetic is PTR_W wide, so the wrap is free.
    assign idx = rd_ptr + PTR_W'(gi);
    assign window[8*gi +: 8] = buf_mem[idx];
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: requests 64-byte lines, buffers the response
// beats in a circular byte buffer and serves a 15-byte decode window.
module fetch_queue #(
  parameter int BUF_BYTES     = 128,
  parameter int LINE_BYTES    = fetch_pkg::LINE_BYTES,
  parameter int WINDOW_BYTES  = 15,
  parameter int REFILL_MARGIN = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  input  logic                      redirect,
  input  logic [63:0]               redirect_rip,
  output logic                      reqcyc,
  output logic [63:0]               req,
  output logic [12:0]               reqtag,
  input  logic                      reqack,
  input  logic                      respcyc,
  input  logic [63:0]               resp,
  output logic                      respack,
  output logic                      dec_valid,
  output logic [8*WINDOW_BYTES-1:0] dec_bytes,
  output logic [63:0]               dec_rip,
  input  logic [3:0]                dec_consume
);
  import fetch_pkg::*;

  localparam int          PTR_W     = $clog2(BUF_BYTES);
  localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);

  fetch_state_t     state_reg, state_next;
  logic [2:0]       beat_cnt_reg, beat_cnt_next;
  logic [2:0]       skip_beats_reg, skip_beats_next;
  logic [63:0]      fetch_line_reg, fetch_line_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [63:0]      dec_rip_reg, dec_rip_next;
  logic             reqcyc_reg, reqcyc_next;

  logic [7:0]       buf_mem [BUF_BYTES];
  logic [PTR_W-1:0] occupancy;
  logic [PTR_W-1:0] wr_base;
  logic             beat_valid, last_beat, beat_write;

  assign occupancy = wr_ptr_reg - rd_ptr_reg;
  // Beats always land 8-aligned; a partial first beat still starts at offset 0.
  assign wr_base   = {wr_ptr_reg[PTR_W-1:3], 3'b000};

  assign reqcyc    = reqcyc_reg;
  assign req       = fetch_line_reg;
  assign reqtag    = {TAG_READ, TAG_MEMORY, 8'b0};
  assign respack   = respcyc;
  assign dec_valid = occupancy >= PTR_W'(WINDOW_BYTES);
  assign dec_rip   = dec_rip_reg;

  always_comb begin
    state_next      = state_reg;
    beat_cnt_next   = beat_cnt_reg;
    skip_beats_next = skip_beats_reg;
    fetch_line_next = fetch_line_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg + PTR_W'(dec_consume);
    dec_rip_next    = dec_rip_reg + 64'(dec_consume);
    reqcyc_next     = reqcyc_reg;

    beat_valid = respcyc && (state_reg != IDLE);
    last_beat  = beat_valid && (beat_cnt_reg == 3'(BEATS_PER_LINE - 1));
    beat_write = beat_valid && (state_reg != DRAIN) && !redirect
                 && (beat_cnt_reg >= skip_beats_reg);

    if (beat_valid) beat_cnt_next = beat_cnt_reg + 3'd1;
    if (beat_write) wr_ptr_next = wr_base + PTR_W'(8);

    case (state_reg)
      IDLE: begin
        if (reqcyc_reg && reqack) begin
          reqcyc_next   = 1'b0;
          beat_cnt_next = 3'd0;
          state_next    = WAIT;
        end else if (!reqcyc_reg && !redirect
                     && occupancy < PTR_W'(REFILL_MARGIN)) begin
          reqcyc_next = 1'b1;
        end
      end
      WAIT: begin
        if (beat_valid) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (last_beat) begin
          state_next      = IDLE;
          fetch_line_next = fetch_line_reg + 64'(LINE_BYTES);
          skip_beats_next = 3'd0;
        end
      end
      DRAIN: begin
        if (last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Redirect overrides any same-cycle beat write and consume.
    if (redirect) begin
      fetch_line_next = redirect_rip & LINE_MASK;
      skip_beats_next = redirect_rip[5:3];
      wr_ptr_next     = {{(PTR_W-3){1'b0}}, redirect_rip[2:0]};
      rd_ptr_next     = {{(PTR_W-3){1'b0}}, redirect_rip[2:0]};
      dec_rip_next    = redirect_rip;
      if (state_reg == IDLE) begin
        // An acked request still owes 8 beats; an unacked one is withdrawn.
        if (reqcyc_reg && reqack) state_next = DRAIN;
        else reqcyc_next = 1'b0;
      end else if (!last_beat) begin
        state_next = DRAIN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      beat_cnt_reg   <= 3'd0;
      skip_beats_reg <= entry[5:3];
      fetch_line_reg <= entry & LINE_MASK;
      wr_ptr_reg     <= {{(PTR_W-3){1'b0}}, entry[2:0]};
      rd_ptr_reg     <= {{(PTR_W-3){1'b0}}, entry[2:0]};
      dec_rip_reg    <= entry;
      reqcyc_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      beat_cnt_reg   <= beat_cnt_next;
      skip_beats_reg <= skip_beats_next;
      fetch_line_reg <= fetch_line_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      dec_rip_reg    <= dec_rip_next;
      reqcyc_reg     <= reqcyc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_write) begin
      for (int k = 0; k < 8; k++) begin
        buf_mem[wr_base + PTR_W'(k)] <= resp[8*k +: 8];
      end
    end
  end

  fetch_window_mux #(
    .BUF_BYTES   (BUF_BYTES),
    .WINDOW_BYTES(WINDOW_BYTES),
    .PTR_W       (PTR_W)
  ) u_window (
    .buf_mem(buf_mem),
    .rd_ptr (rd_ptr_reg),
    .window (dec_bytes)
  );

  // Refill margin plus one line bounds occupancy well below the buffer size.
  assert property (@(posedge clk) disable iff (reset)
    occupancy <= PTR_W'(LINE_BYTES + REFILL_MARGIN - 1));
  assert property (@(posedge clk) disable iff (reset)
    !(dec_consume != 4'd0 && !dec_valid));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a line-read bus responder whose memory
// holds byte value (address & 0xFF), table vectors plus corner sequences.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [63:0]  entry = 64'h0;
  logic         redirect = 1'b0;
  logic [63:0]  redirect_rip = 64'h0;
  logic         reqcyc;
  logic [63:0]  req;
  logic [12:0]  reqtag;
  logic         reqack;
  logic         respcyc;
  logic [63:0]  resp;
  logic         respack;
  logic         dec_valid;
  logic [119:0] dec_bytes;
  logic [63:0]  dec_rip;
  logic [3:0]   dec_consume = 4'd0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .entry       (entry),
    .redirect    (redirect),
    .redirect_rip(redirect_rip),
    .reqcyc      (reqcyc),
    .req         (req),
    .reqtag      (reqtag),
    .reqack      (reqack),
    .respcyc     (respcyc),
    .resp        (resp),
    .respack     (respack),
    .dec_valid   (dec_valid),
    .dec_bytes   (dec_bytes),
    .dec_rip     (dec_rip),
    .dec_consume (dec_consume)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] req_log[$];
  int          resp_gap = 0;
  int          bus_phase = 0;
  int          gap_left = 0;
  int          bus_beat = 0;
  int          cur_beat = -1;
  logic [63:0] bus_line = 64'h0;
  int          beats_done = 0;

  function automatic logic [63:0] beat_data(logic [63:0] line, int b);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(line + 64'(8*b + k));
    return d;
  endfunction

  function automatic logic [119:0] exp_window(logic [63:0] rip);
    logic [119:0] w;
    for (int k = 0; k < 15; k++) w[8*k +: 8] = 8'(rip + 64'(k));
    return w;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus slave: ack one cycle after reqcyc is seen, then 8 back-to-back beats.
  initial begin
    reqack  = 1'b0;
    respcyc = 1'b0;
    resp    = 64'h0;
    forever begin
      @(negedge clk);
      reqack  = 1'b0;
      respcyc = 1'b0;
      if (reset) begin
        bus_phase = 0;
      end else if (bus_phase == 0) begin
        if (reqcyc) begin
          reqack   = 1'b1;
          bus_line = req;
          req_log.push_back(req);
          bus_phase = 1;
          gap_left  = resp_gap;
          bus_beat  = 0;
        end
      end else if (gap_left > 0) begin
        gap_left--;
      end else begin
        respcyc  = 1'b1;
        resp     = beat_data(bus_line, bus_beat);
        cur_beat = bus_beat;
        bus_beat++;
        if (bus_beat == 8) bus_phase = 0;
      end
    end
  end

  always @(posedge clk) if (respcyc && !reset) beats_done <= beats_done + 1;

  task automatic do_reset(logic [63:0] rip);
    redirect    = 1'b0;
    dec_consume = 4'd0;
    entry       = rip;
    reset       = 1'b1;
    repeat (2) @(negedge clk);
    req_log.delete();
    reset = 1'b0;
  endtask

  task automatic wait_valid(string name, int limit);
    int waited;
    waited = 0;
    while (!dec_valid && waited < limit) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!dec_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: dec_valid got 0 expected 1 within %0d cycles", name, limit);
    end
  endtask

  function automatic logic [63:0] log_at(int i);
    if (i < req_log.size()) return req_log[i];
    return '1;
  endfunction

  typedef struct {
    logic [63:0] rip;
    logic [63:0] exp_req;
    int          exp_beats;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0] exp_rip;
    int          base;
    int          found;
    int          bad;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_rip;
    int          base;
    int          found;
    int          bad;

    // beats = all bus beats (dropped ones included) up to dec_valid
    vecs[0] = '{64'h0000_0000_0000_1000, 64'h0000_0000_0000_1000, 2};
    vecs[1] = '{64'h0000_0000_0000_102B, 64'h0000_0000_0000_1000, 8};
    vecs[2] = '{64'h0000_0000_0000_1031, 64'h0000_0000_0000_1000, 8};
    vecs[3] = '{64'h0000_0000_0000_1032, 64'h0000_0000_0000_1000, 9};
    vecs[4] = '{64'h0000_0000_0000_203F, 64'h0000_0000_0000_2000, 10};
    vecs[5] = '{64'h1234_5678_9ABC_DEF7, 64'h1234_5678_9ABC_DEC0, 9};

    for (int v = 0; v < 6; v++) begin
      entry = vecs[v].rip;
      reset = 1'b1;
      #1;
      check("rst_reqcyc", 128'(reqcyc), 128'(0));
      check("rst_req", 128'(req), 128'(vecs[v].exp_req));
      check("rst_reqtag", 128'(reqtag), 128'(13'h1100));
      check("rst_dec_valid", 128'(dec_valid), 128'(0));
      check("rst_dec_rip", 128'(dec_rip), 128'(vecs[v].rip));
      repeat (2) @(negedge clk);
      req_log.delete();
      base  = beats_done;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("first_reqcyc", 128'(reqcyc), 128'(1));
      check("first_req", 128'(req), 128'(vecs[v].exp_req));
      wait_valid("vec_valid", 100);
      check("vec_log_req", 128'(log_at(0)), 128'(vecs[v].exp_req));
      check("vec_beats", 128'(beats_done - base), 128'(vecs[v].exp_beats));
      check("vec_dec_rip", 128'(dec_rip), 128'(vecs[v].rip));
      check("vec_window", 128'(dec_bytes), 128'(exp_window(vecs[v].rip)));
      $display("vector %0d rip=%h beats=%0d byte0=%h", v, vecs[v].rip,
               beats_done - base, dec_bytes[7:0]);
    end

    // Continuous 15-byte consumption: window and RIP track memory, buffer wraps.
    do_reset(64'h1000);
    exp_rip = 64'h1000;
    for (int c = 0; c < 3000 && exp_rip < 64'h1000 + 64'd600; c++) begin
      @(negedge clk);
      #1;
      if (dec_valid) begin
        check("stream_rip", 128'(dec_rip), 128'(exp_rip));
        check("stream_window", 128'(dec_bytes), 128'(exp_window(exp_rip)));
        dec_consume = 4'd15;
        exp_rip     = exp_rip + 64'd15;
      end else begin
        dec_consume = 4'd0;
      end
    end
    dec_consume = 4'd0;
    check("stream_progress", 128'(exp_rip >= 64'h1000 + 64'd600), 128'(1));
    bad = 0;
    for (int i = 0; i < req_log.size(); i++)
      if (req_log[i] != 64'h1000 + 64'(64 * i)) bad++;
    check("stream_req_seq", 128'(bad), 128'(0));
    check("stream_req_cnt", 128'(req_log.size() >= 9), 128'(1));
    $display("stream consumed to rip=%h with %0d line requests", exp_rip, req_log.size());

    // No consumption: one line fills, occupancy 64 blocks further requests.
    do_reset(64'h1000);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      check("respack_echo", 128'(respack), 128'(respcyc));
    end
    check("hold_req_cnt", 128'(req_log.size()), 128'(1));
    check("hold_reqcyc", 128'(reqcyc), 128'(0));
    check("hold_valid", 128'(dec_valid), 128'(1));
    check("hold_occupancy", 128'(dut.occupancy), 128'(64));
    check("hold_window", 128'(dec_bytes), 128'(exp_window(64'h1000)));
    $display("hold test requests=%0d occupancy=%0d", req_log.size(), dut.occupancy);

    // Redirect during beat 3 of an active line.
    do_reset(64'h1000);
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(negedge clk);
      #1;
      if (respcyc && cur_beat == 3) found = 1;
    end
    check("redir_beat3_seen", 128'(found), 128'(1));
    check("redir_pre_valid", 128'(dec_valid), 128'(1));
    redirect_rip = 64'h2005;
    redirect     = 1'b1;
    @(negedge clk);
    #1;
    redirect = 1'b0;
    check("redir_valid_drop", 128'(dec_valid), 128'(0));
    check("redir_state", 128'(dut.state_reg), 128'(DRAIN));
    check("redir_dec_rip", 128'(dec_rip), 128'(64'h2005));
    wait_valid("redir_valid", 100);
    check("redir_req_cnt", 128'(req_log.size()), 128'(2));
    check("redir_req", 128'(log_at(1)), 128'(64'h2000));
    check("redir_window", 128'(dec_bytes), 128'(exp_window(64'h2005)));
    check("redir_rip_after", 128'(dec_rip), 128'(64'h2005));
    $display("redirect to 2005 refetched line %h byte0=%h", log_at(1), dec_bytes[7:0]);

    // Asynchronous reset while waiting for the first beat.
    resp_gap = 6;
    do_reset(64'h1000);
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      #1;
      if (req_log.size() > 0) found = 1;
    end
    check("wait_req_seen", 128'(found), 128'(1));
    @(posedge clk);
    #3;
    check("wait_state", 128'(dut.state_reg), 128'(WAIT));
    entry = 64'h3008;
    reset = 1'b1;
    #1;
    check("arst_reqcyc", 128'(reqcyc), 128'(0));
    check("arst_state", 128'(dut.state_reg), 128'(IDLE));
    check("arst_req", 128'(req), 128'(64'h3000));
    check("arst_dec_rip", 128'(dec_rip), 128'(64'h3008));
    check("arst_valid", 128'(dec_valid), 128'(0));
    resp_gap = 0;
    @(negedge clk);
    @(negedge clk);
    req_log.delete();
    reset = 1'b0;
    wait_valid("arst_valid_after", 100);
    check("arst_req_after", 128'(log_at(0)), 128'(64'h3000));
    check("arst_window", 128'(dec_bytes), 128'(exp_window(64'h3008)));
    $display("reset in WAIT recovered at rip=%h", dec_rip);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
